// File: rtl/ahb3lite_dma_pkg.sv
// Shared AHB3-Lite encodings and the address/control payload for the DMA master arbiter.
package ahb3lite_dma_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              write;
      logic [2:0]        size;
      logic [2:0]        burst;
      logic [3:0]        prot;
      logic [1:0]        trans;
   } ahb_addr_ctrl_t;

endpackage

// File: rtl/ahb3lite_dma_arb_hold.sv
// Per-master input stage: parks an accepted address phase that could not go out live,
// and presents either the parked copy or the live bus to the arbiter.
module ahb3lite_dma_arb_hold
   import ahb3lite_dma_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  ahb_addr_ctrl_t i_live,
   input  logic           i_up_ready,
   input  logic           i_granted,
   input  logic           i_dn_ready,
   output ahb_addr_ctrl_t o_sel_c,
   output logic           o_req_c,
   output logic           o_hold_vld
);

   ahb_addr_ctrl_t r_hold;
   logic           r_hold_vld;
   logic           w_live_out;
   logic           w_capture;
   logic           w_release;

   // A live transfer leaving downstream this edge needs no parking.
   assign w_live_out = i_granted & ~r_hold_vld & i_dn_ready;
   assign w_capture  = i_up_ready & i_live.trans[1] & ~w_live_out;
   assign w_release  = r_hold_vld & i_granted & i_dn_ready;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_hold_vld <= 1'b0;
         r_hold     <= '0;
      end else if (w_capture) begin
         r_hold_vld <= 1'b1;
         r_hold     <= i_live;
      end else if (w_release) begin
         r_hold_vld <= 1'b0;
      end
   end

   assign o_sel_c    = r_hold_vld ? r_hold : i_live;
   assign o_req_c    = r_hold_vld | i_live.trans[1];
   assign o_hold_vld = r_hold_vld;

endmodule

// File: rtl/ahb3lite_dma_arb.sv
// Two-to-one AHB3-Lite arbiter merging the DMA m0/m1 master ports onto one master port.
// Define AHB3LITE_DMA_ARB_RR_EN for round-robin; otherwise master 0 has fixed priority.
module ahb3lite_dma_arb
   import ahb3lite_dma_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              in0HSEL,
   input  logic [ADDR_W-1:0] in0HADDR,
   input  logic [DATA_W-1:0] in0HWDATA,
   input  logic              in0HWRITE,
   input  logic [2:0]        in0HSIZE,
   input  logic [2:0]        in0HBURST,
   input  logic [3:0]        in0HPROT,
   input  logic [1:0]        in0HTRANS,
   input  logic              in0HREADYOUT,
   output logic [DATA_W-1:0] in0HRDATA,
   output logic              in0HREADY,
   output logic              in0HRESP,
   input  logic              in1HSEL,
   input  logic [ADDR_W-1:0] in1HADDR,
   input  logic [DATA_W-1:0] in1HWDATA,
   input  logic              in1HWRITE,
   input  logic [2:0]        in1HSIZE,
   input  logic [2:0]        in1HBURST,
   input  logic [3:0]        in1HPROT,
   input  logic [1:0]        in1HTRANS,
   input  logic              in1HREADYOUT,
   output logic [DATA_W-1:0] in1HRDATA,
   output logic              in1HREADY,
   output logic              in1HRESP,
   output logic              mHSEL,
   output logic [ADDR_W-1:0] mHADDR,
   output logic [DATA_W-1:0] mHWDATA,
   output logic              mHWRITE,
   output logic [2:0]        mHSIZE,
   output logic [2:0]        mHBURST,
   output logic [3:0]        mHPROT,
   output logic [1:0]        mHTRANS,
   input  logic [DATA_W-1:0] mHRDATA,
   input  logic              mHREADY,
   input  logic              mHRESP
);

   logic           r_gnt;
   logic           r_dph_vld;
   logic           r_dph_own;
   ahb_addr_ctrl_t w_live0, w_live1, w_sel0, w_sel1, w_src;
   logic           w_req0, w_req1, w_hold0, w_hold1, w_src_req;
   logic [1:0]     w_trans;
   logic           w_locked;
   logic           w_gnt_nxt;
   logic           w_unused;

   assign w_unused = ^{in0HSEL, in0HREADYOUT, in1HSEL, in1HREADYOUT};

   assign w_live0 = '{addr: in0HADDR, write: in0HWRITE, size: in0HSIZE,
                      burst: in0HBURST, prot: in0HPROT, trans: in0HTRANS};
   assign w_live1 = '{addr: in1HADDR, write: in1HWRITE, size: in1HSIZE,
                      burst: in1HBURST, prot: in1HPROT, trans: in1HTRANS};

   ahb3lite_dma_arb_hold u_hold0 (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .i_live     (w_live0),
      .i_up_ready (in0HREADY),
      .i_granted  (~r_gnt),
      .i_dn_ready (mHREADY),
      .o_sel_c    (w_sel0),
      .o_req_c    (w_req0),
      .o_hold_vld (w_hold0)
   );

   ahb3lite_dma_arb_hold u_hold1 (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .i_live     (w_live1),
      .i_up_ready (in1HREADY),
      .i_granted  (r_gnt),
      .i_dn_ready (mHREADY),
      .o_sel_c    (w_sel1),
      .o_req_c    (w_req1),
      .o_hold_vld (w_hold1)
   );

   // Address-phase mux; everything reads as zero while reset is asserted.
   assign w_src     = r_gnt ? w_sel1 : w_sel0;
   assign w_src_req = r_gnt ? w_req1 : w_req0;
   assign w_trans   = (rst_n_i && w_src_req) ? w_src.trans : HTRANS_IDLE;
   assign mHTRANS   = w_trans;
   assign mHSEL     = w_trans[1];
   assign mHADDR    = rst_n_i ? w_src.addr  : '0;
   assign mHWRITE   = rst_n_i ? w_src.write : 1'b0;
   assign mHSIZE    = rst_n_i ? w_src.size  : '0;
   assign mHBURST   = rst_n_i ? w_src.burst : '0;
   assign mHPROT    = rst_n_i ? w_src.prot  : '0;
   assign mHWDATA   = !rst_n_i ? '0 : (r_dph_own ? in1HWDATA : in0HWDATA);

   assign in0HRDATA = mHRDATA;
   assign in1HRDATA = mHRDATA;

   // Response routing: data-phase owner sees the slave, a parked master is stalled.
   always_comb begin
      in0HREADY = 1'b1;
      in0HRESP  = 1'b0;
      in1HREADY = 1'b1;
      in1HRESP  = 1'b0;
      if (rst_n_i) begin
         if (r_dph_vld && !r_dph_own) begin
            in0HREADY = mHREADY;
            in0HRESP  = mHRESP;
         end else if (w_hold0) begin
            in0HREADY = 1'b0;
         end
         if (r_dph_vld && r_dph_own) begin
            in1HREADY = mHREADY;
            in1HRESP  = mHRESP;
         end else if (w_hold1) begin
            in1HREADY = 1'b0;
         end
      end
   end

   // Bursts keep the grant until an IDLE or a SINGLE NONSEQ goes out.
   assign w_locked = (w_trans == HTRANS_SEQ) || (w_trans == HTRANS_BUSY) ||
                     ((w_trans == HTRANS_NONSEQ) && (mHBURST != HBURST_SINGLE));

   always_comb begin
      w_gnt_nxt = r_gnt;
      if (w_req0 && w_req1) begin
`ifdef AHB3LITE_DMA_ARB_RR_EN
         w_gnt_nxt = ~r_gnt;
`else
         w_gnt_nxt = 1'b0;
`endif
      end else if (w_req0) begin
         w_gnt_nxt = 1'b0;
      end else if (w_req1) begin
         w_gnt_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_gnt     <= 1'b0;
         r_dph_vld <= 1'b0;
         r_dph_own <= 1'b0;
      end else if (mHREADY) begin
         r_dph_vld <= w_trans[1];
         r_dph_own <= r_gnt;
         if (!w_locked) r_gnt <= w_gnt_nxt;
      end
   end

endmodule

// File: tb/tb_ahb3lite_dma_arb.sv
// Directed bench for ahb3lite_dma_arb in its default fixed-priority build.
module tb_ahb3lite_dma_arb;
   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        in0HSEL, in0HWRITE, in0HREADYOUT, in0HREADY, in0HRESP;
   logic [31:0] in0HADDR, in0HWDATA, in0HRDATA;
   logic [2:0]  in0HSIZE, in0HBURST;
   logic [3:0]  in0HPROT;
   logic [1:0]  in0HTRANS;
   logic        in1HSEL, in1HWRITE, in1HREADYOUT, in1HREADY, in1HRESP;
   logic [31:0] in1HADDR, in1HWDATA, in1HRDATA;
   logic [2:0]  in1HSIZE, in1HBURST;
   logic [3:0]  in1HPROT;
   logic [1:0]  in1HTRANS;
   logic        mHSEL, mHWRITE, mHREADY, mHRESP;
   logic [31:0] mHADDR, mHWDATA, mHRDATA;
   logic [2:0]  mHSIZE, mHBURST;
   logic [3:0]  mHPROT;
   logic [1:0]  mHTRANS;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   ahb3lite_dma_arb dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .in0HSEL(in0HSEL), .in0HADDR(in0HADDR), .in0HWDATA(in0HWDATA), .in0HWRITE(in0HWRITE),
      .in0HSIZE(in0HSIZE), .in0HBURST(in0HBURST), .in0HPROT(in0HPROT), .in0HTRANS(in0HTRANS),
      .in0HREADYOUT(in0HREADYOUT), .in0HRDATA(in0HRDATA), .in0HREADY(in0HREADY), .in0HRESP(in0HRESP),
      .in1HSEL(in1HSEL), .in1HADDR(in1HADDR), .in1HWDATA(in1HWDATA), .in1HWRITE(in1HWRITE),
      .in1HSIZE(in1HSIZE), .in1HBURST(in1HBURST), .in1HPROT(in1HPROT), .in1HTRANS(in1HTRANS),
      .in1HREADYOUT(in1HREADYOUT), .in1HRDATA(in1HRDATA), .in1HREADY(in1HREADY), .in1HRESP(in1HRESP),
      .mHSEL(mHSEL), .mHADDR(mHADDR), .mHWDATA(mHWDATA), .mHWRITE(mHWRITE),
      .mHSIZE(mHSIZE), .mHBURST(mHBURST), .mHPROT(mHPROT), .mHTRANS(mHTRANS),
      .mHRDATA(mHRDATA), .mHREADY(mHREADY), .mHRESP(mHRESP)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic [2:0] b, input logic [31:0] wd);
      in0HTRANS = t; in0HSEL = t[1]; in0HADDR = a; in0HWRITE = w; in0HBURST = b; in0HWDATA = wd;
   endtask

   task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic [2:0] b, input logic [31:0] wd);
      in1HTRANS = t; in1HSEL = t[1]; in1HADDR = a; in1HWRITE = w; in1HBURST = b; in1HWDATA = wd;
   endtask

   initial begin
      rst_n_i = 1'b0;
      in0HSIZE = 3'b010; in0HPROT = 4'b0011; in0HREADYOUT = 1'b1;
      in1HSIZE = 3'b010; in1HPROT = 4'b0011; in1HREADYOUT = 1'b1;
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      drv1(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      mHREADY = 1'b1; mHRESP = 1'b0; mHRDATA = 32'h0;

      // Reset: outputs gated even with a live request present.
      next_cycle();
      drv0(2'b10, 32'h1234, 1'b0, 3'b000, 32'h0);
      settle();
      chk("rst_htrans", 32'(mHTRANS), 32'h0);
      chk("rst_haddr", mHADDR, 32'h0);
      chk("rst_rdy0", 32'(in0HREADY), 32'h1);
      chk("rst_rdy1", 32'(in1HREADY), 32'h1);
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      next_cycle();
      rst_n_i = 1'b1;

      // Single-master passthrough.
      next_cycle();
      drv0(2'b10, 32'h1000, 1'b0, 3'b000, 32'h0);
      settle();
      chk("pt_haddr", mHADDR, 32'h1000);
      chk("pt_htrans", 32'(mHTRANS), 32'h2);
      chk("pt_hsel", 32'(mHSEL), 32'h1);
      chk("pt_hsize", 32'(mHSIZE), 32'h2);
      chk("pt_hprot", 32'(mHPROT), 32'h3);
      chk("pt_rdy1_a", 32'(in1HREADY), 32'h1);
      next_cycle();
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      mHRDATA = 32'hCAFEF00D;
      settle();
      chk("pt_rdata0", in0HRDATA, 32'hCAFEF00D);
      chk("pt_rdata1", in1HRDATA, 32'hCAFEF00D);
      chk("pt_rdy0", 32'(in0HREADY), 32'h1);
      chk("pt_rdy1_d", 32'(in1HREADY), 32'h1);
      chk("pt_idle", 32'(mHTRANS), 32'h0);

      // Simultaneous writes: master 0 live, master 1 parked then issued.
      next_cycle();
      mHRDATA = 32'h0;
      drv0(2'b10, 32'h2000, 1'b1, 3'b000, 32'h0);
      drv1(2'b10, 32'h3000, 1'b1, 3'b000, 32'h0);
      settle();
      chk("sim_haddr0", mHADDR, 32'h2000);
      chk("sim_hwrite0", 32'(mHWRITE), 32'h1);
      chk("sim_rdy1_a", 32'(in1HREADY), 32'h1);
      next_cycle();
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'hAAAA0000);
      drv1(2'b00, 32'h0, 1'b0, 3'b000, 32'hBBBB1111);
      settle();
      chk("sim_gap_idle", 32'(mHTRANS), 32'h0);
      chk("sim_wdata0", mHWDATA, 32'hAAAA0000);
      chk("sim_rdy1_hold", 32'(in1HREADY), 32'h0);
      chk("sim_rdy0", 32'(in0HREADY), 32'h1);
      next_cycle();
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      settle();
      chk("sim_haddr1", mHADDR, 32'h3000);
      chk("sim_htrans1", 32'(mHTRANS), 32'h2);
      chk("sim_hwrite1", 32'(mHWRITE), 32'h1);
      chk("sim_rdy1_addr", 32'(in1HREADY), 32'h0);
      next_cycle();
      settle();
      chk("sim_wdata1", mHWDATA, 32'hBBBB1111);
      chk("sim_rdy1_done", 32'(in1HREADY), 32'h1);

      // Burst lock: master 1 INCR4, master 0 requests after the first beat.
      next_cycle();
      drv1(2'b10, 32'h4000, 1'b0, 3'b011, 32'h0);
      settle();
      chk("bl_beat0", mHADDR, 32'h4000);
      chk("bl_burst", 32'(mHBURST), 32'h3);
      next_cycle();
      drv1(2'b11, 32'h4004, 1'b0, 3'b011, 32'h0);
      drv0(2'b10, 32'h5000, 1'b0, 3'b000, 32'h0);
      settle();
      chk("bl_beat1", mHADDR, 32'h4004);
      next_cycle();
      drv1(2'b11, 32'h4008, 1'b0, 3'b011, 32'h0);
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      settle();
      chk("bl_beat2", mHADDR, 32'h4008);
      chk("bl_rdy0_b2", 32'(in0HREADY), 32'h0);
      next_cycle();
      drv1(2'b11, 32'h400C, 1'b0, 3'b011, 32'h0);
      settle();
      chk("bl_beat3", mHADDR, 32'h400C);
      chk("bl_htrans3", 32'(mHTRANS), 32'h3);
      next_cycle();
      drv1(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      settle();
      chk("bl_gap", 32'(mHTRANS), 32'h0);
      next_cycle();
      settle();
      chk("bl_m0_addr", mHADDR, 32'h5000);
      chk("bl_m0_trans", 32'(mHTRANS), 32'h2);
      next_cycle();
      settle();
      chk("bl_m0_done", 32'(in0HREADY), 32'h1);

      // Fixed priority: eight back-to-back master 0 transfers, master 1 starved.
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         drv0(2'b10, 32'h6000 + 32'(4 * k), 1'b0, 3'b000, 32'h0);
         if (k == 0) drv1(2'b10, 32'h7000, 1'b0, 3'b000, 32'h0);
         else        drv1(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
         settle();
         chk($sformatf("fp_addr%0d", k), mHADDR, 32'h6000 + 32'(4 * k));
         if (k > 0) chk($sformatf("fp_rdy1_%0d", k), 32'(in1HREADY), 32'h0);
      end
      next_cycle();
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      drv1(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      settle();
      chk("fp_gap", 32'(mHTRANS), 32'h0);

      // Master 1's parked read goes out, then an ERROR response comes back to it only.
      next_cycle();
      settle();
      chk("er_addr", mHADDR, 32'h7000);
      chk("er_trans", 32'(mHTRANS), 32'h2);
      next_cycle();
      mHREADY = 1'b0; mHRESP = 1'b1;
      settle();
      chk("er1_resp1", 32'(in1HRESP), 32'h1);
      chk("er1_rdy1", 32'(in1HREADY), 32'h0);
      chk("er1_resp0", 32'(in0HRESP), 32'h0);
      next_cycle();
      mHREADY = 1'b1; mHRESP = 1'b1;
      settle();
      chk("er2_resp1", 32'(in1HRESP), 32'h1);
      chk("er2_rdy1", 32'(in1HREADY), 32'h1);
      chk("er2_resp0", 32'(in0HRESP), 32'h0);
      next_cycle();
      mHRESP = 1'b0;
      settle();
      chk("er_after", 32'(in1HRESP), 32'h0);

      // Reset while master 1 is parked: the parked transfer is dropped.
      next_cycle();
      drv0(2'b10, 32'h8000, 1'b0, 3'b000, 32'h0);
      settle();
      chk("rh_idle", 32'(mHTRANS), 32'h0);
      next_cycle();
      drv0(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      drv1(2'b10, 32'hA000, 1'b0, 3'b000, 32'h0);
      settle();
      chk("rh_m0", mHADDR, 32'h8000);
      next_cycle();
      drv1(2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
      settle();
      chk("rh_held", 32'(in1HREADY), 32'h0);
      rst_n_i = 1'b0;
      #1;
      chk("rh_rst_trans", 32'(mHTRANS), 32'h0);
      chk("rh_rst_rdy1", 32'(in1HREADY), 32'h1);
      chk("rh_rst_rdy0", 32'(in0HREADY), 32'h1);
      next_cycle();
      rst_n_i = 1'b1;
      settle();
      chk("rh_post_rdy1", 32'(in1HREADY), 32'h1);
      chk("rh_post_rdy0", 32'(in0HREADY), 32'h1);
      chk("rh_post_trans", 32'(mHTRANS), 32'h0);
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         settle();
         chk($sformatf("rh_never%0d", k), 32'(mHTRANS), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
